// File: rtl/inst_fetch_ctrl_pkg.sv
// Fetch front-end shared types, opcode constants and immediate helpers.
// Also used by the decoder for JAL/branch immediate extraction.
package inst_fetch_ctrl_pkg;

  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [31:0] INST_STEP = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_MEM,
    S_DISCARD
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } fq_entry_t;

  typedef struct packed {
    logic [31:0] next_pc;
    logic        taken;
  } fetch_pred_t;

  function automatic logic [6:0] opcode(input logic [31:0] i);
    return i[6:0];
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_queue.sv
// inst_queue: power-of-two FIFO of fetched words with synchronous clear.
// Storage is not reset; only pointers and count are.
module inst_queue
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  fq_entry_t                push_data,
  input  logic                     pop,
  input  logic                     clr,
  output fq_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  fq_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push && !clr) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_MAX);

  a_no_overflow : assert property (
    @(posedge clk_in) disable iff (rst_in)
    push && !clr |-> !full || pop);

  a_no_underflow : assert property (
    @(posedge clk_in) disable iff (rst_in)
    pop && !clr |-> count_q != '0);

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, icache handshake, issue queue.
// FETCH_STATIC_PREDICT_EN enables static JAL/backward-branch prediction.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        icache_req_out,
  output logic [31:0] icache_addr_out,
  input  logic        icache_ready_in,
  input  logic [31:0] icache_data_in,
  input  logic        issue_full_in,
  input  logic        flush_in,
  input  logic [31:0] flush_pc_in,
  output logic        dec_req_out,
  output logic [31:0] dec_inst_out,
  output logic [31:0] dec_pc_out,
  output logic        dec_pred_out
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic         dec_req_q, dec_req_d;
  logic [31:0]  dec_inst_q, dec_inst_d;
  logic [31:0]  dec_pc_q, dec_pc_d;
  logic         dec_pred_q, dec_pred_d;

  logic          q_push, q_pop, q_clr, q_full;
  logic [CW-1:0] q_count;
  fq_entry_t     q_head, q_in;
  fetch_pred_t   pred;

  inst_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .clr       (q_clr),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full)
  );

  always_comb begin
    pred.next_pc = fetch_pc_q + INST_STEP;
    pred.taken   = 1'b0;
`ifdef FETCH_STATIC_PREDICT_EN
    unique case (1'b1)
      opcode(icache_data_in) == OP_JAL: begin
        pred.next_pc = fetch_pc_q + imm_j(icache_data_in);
        pred.taken   = 1'b1;
      end
      opcode(icache_data_in) == OP_BRANCH && icache_data_in[31]: begin
        pred.next_pc = fetch_pc_q + imm_b(icache_data_in);
        pred.taken   = 1'b1;
      end
      default: ;
    endcase
`endif
  end

  assign q_in = '{inst: icache_data_in, pc: fetch_pc_q, pred: pred.taken};

  // issue path: queue head goes to registered decoder outputs
  always_comb begin
    q_pop = rdy_in && !flush_in && !issue_full_in && (q_count != '0);
    dec_req_d  = q_pop;
    dec_inst_d = dec_inst_q;
    dec_pc_d   = dec_pc_q;
    dec_pred_d = dec_pred_q;
    if (q_pop) begin
      dec_inst_d = q_head.inst;
      dec_pc_d   = q_head.pc;
      dec_pred_d = q_head.pred;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    q_push     = 1'b0;
    q_clr      = 1'b0;
    if (rdy_in) begin
      if (flush_in) begin
        q_clr      = 1'b1;
        fetch_pc_d = flush_pc_in;
      end
      unique case (state_q)
        S_IDLE: begin
          if (!flush_in && !q_full) begin
            state_d    = S_WAIT_MEM;
            req_addr_d = fetch_pc_q;
          end
        end
        S_WAIT_MEM: begin
          if (flush_in) begin
            state_d = icache_ready_in ? S_IDLE : S_DISCARD;
          end else if (icache_ready_in) begin
            q_push     = 1'b1;
            fetch_pc_d = pred.next_pc;
            state_d    = S_IDLE;
          end
        end
        // request stays up at the old address until the cache answers
        S_DISCARD: begin
          if (icache_ready_in) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      dec_req_q  <= 1'b0;
      dec_inst_q <= '0;
      dec_pc_q   <= '0;
      dec_pred_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      dec_req_q  <= dec_req_d;
      dec_inst_q <= dec_inst_d;
      dec_pc_q   <= dec_pc_d;
      dec_pred_q <= dec_pred_d;
    end
  end

  assign icache_req_out  = (state_q != S_IDLE);
  assign icache_addr_out = req_addr_q;
  assign dec_req_out     = dec_req_q && rdy_in;
  assign dec_inst_out    = dec_inst_q;
  assign dec_pc_out      = dec_pc_q;
  assign dec_pred_out    = dec_pred_q;

  a_addr_stable : assert property (
    @(posedge clk_in) disable iff (rst_in)
    icache_req_out && !icache_ready_in |=>
      icache_req_out && $stable(icache_addr_out));

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Random-stimulus bench for inst_fetch_ctrl against a transaction-level model.
// Build with +define+FETCH_STATIC_PREDICT_EN to cover static prediction.
module tb_inst_fetch_ctrl;

  localparam int          QD  = 4;
  localparam logic [31:0] RPC = 32'h0;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        icache_req_out;
  logic [31:0] icache_addr_out;
  logic        icache_ready_in;
  logic [31:0] icache_data_in;
  logic        issue_full_in;
  logic        flush_in;
  logic [31:0] flush_pc_in;
  logic        dec_req_out;
  logic [31:0] dec_inst_out;
  logic [31:0] dec_pc_out;
  logic        dec_pred_out;

  inst_fetch_ctrl #(.QUEUE_DEPTH(QD), .RESET_PC(RPC)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .icache_req_out  (icache_req_out),
    .icache_addr_out (icache_addr_out),
    .icache_ready_in (icache_ready_in),
    .icache_data_in  (icache_data_in),
    .issue_full_in   (issue_full_in),
    .flush_in        (flush_in),
    .flush_pc_in     (flush_pc_in),
    .dec_req_out     (dec_req_out),
    .dec_inst_out    (dec_inst_out),
    .dec_pc_out      (dec_pc_out),
    .dec_pred_out    (dec_pred_out)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] exp_pc;
  logic [31:0] req_addr;
  logic        req_prev;
  logic        req_flushed;
  int          lat;
  bit          did_reset = 0;

  // returns {predicted_taken, next_fetch_pc}
  function automatic logic [32:0] ref_next(input logic [31:0] pc,
                                           input logic [31:0] w);
`ifdef FETCH_STATIC_PREDICT_EN
    logic signed [20:0] offj;
    logic signed [12:0] offb;
    offj = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
    offb = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
    if (w[6:0] == 7'b1101111) return {1'b1, pc + 32'(offj)};
    if (w[6:0] == 7'b1100011 && w[31]) return {1'b1, pc + 32'(offb)};
`endif
    return {1'b0, pc + 32'd4};
  endfunction

  function automatic logic [31:0] gen_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0:       w[6:0] = 7'b1101111;
      1:       w[6:0] = 7'b1100011;
      default: w[6:0] = 7'b0010011;
    endcase
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_pc      = RPC;
    req_addr    = RPC;
    req_prev    = 1'b0;
    req_flushed = 1'b0;
    lat         = 0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_icache_req"}, icache_req_out, 1'b0);
    check({pfx, "_icache_addr"}, icache_addr_out, RPC);
    check({pfx, "_dec_req"}, dec_req_out, 1'b0);
    check({pfx, "_dec_inst"}, dec_inst_out, 32'h0);
    check({pfx, "_dec_pc"}, dec_pc_out, 32'h0);
    check({pfx, "_dec_pred"}, dec_pred_out, 1'b0);
  endtask

  initial begin
    int          qn;
    logic        exp_req;
    logic        exp_dec;
    logic        accepted;
    logic [32:0] r;
    ent_t        e;

    rst_in          = 1'b1;
    rdy_in          = 1'b1;
    issue_full_in   = 1'b0;
    flush_in        = 1'b0;
    flush_pc_in     = 32'h0;
    icache_ready_in = 1'b0;
    icache_data_in  = 32'h0;
    repeat (2) @(posedge clk_in);
    #1;
    check_reset_outputs("por");
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      // asynchronous reset in the middle of an outstanding request
      if (cyc >= 1500 && !did_reset && icache_req_out) begin
        did_reset = 1;
        #1 rst_in = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk_in);
        #2 rst_in = 1'b0;
        model_reset();
      end

      rdy_in = ($urandom_range(0, 19) != 0);
      if (cyc % 300 >= 100 && cyc % 300 < 120)
        issue_full_in = 1'b1;
      else
        issue_full_in = ($urandom_range(0, 3) == 0);
      flush_in        = rdy_in && ($urandom_range(0, 14) == 0);
      flush_pc_in     = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      icache_ready_in = 1'b0;
      icache_data_in  = $urandom;
      if (icache_req_out && rdy_in) begin
        if (lat == 0) begin
          icache_ready_in = 1'b1;
          icache_data_in  = gen_word();
        end else begin
          lat--;
        end
      end

      @(posedge clk_in);
      #1;

      qn      = mq.size();
      exp_dec = rdy_in && !flush_in && !issue_full_in && (qn > 0);
      check("dec_req", dec_req_out, exp_dec);
      if (dec_req_out && qn > 0) begin
        e = mq.pop_front();
        check("dec_inst", dec_inst_out, e.inst);
        check("dec_pc", dec_pc_out, e.pc);
        check("dec_pred", dec_pred_out, e.pred);
      end

      if (rdy_in) begin
        accepted = icache_ready_in && !flush_in && !req_flushed;
        if (accepted) begin
          r = ref_next(req_addr, icache_data_in);
          mq.push_back('{inst: icache_data_in, pc: req_addr, pred: r[32]});
          exp_pc = r[31:0];
        end
        if (icache_ready_in)
          req_flushed = 1'b0;
        else if (flush_in && req_prev)
          req_flushed = 1'b1;
        if (flush_in) begin
          mq.delete();
          exp_pc = flush_pc_in;
        end
        exp_req = req_prev ? !icache_ready_in : (!flush_in && qn < QD);
      end else begin
        exp_req = req_prev;
      end

      check("icache_req", icache_req_out, exp_req);
      if (exp_req && !req_prev) begin
        check("req_addr", icache_addr_out, exp_pc);
        req_addr = exp_pc;
        lat      = $urandom_range(0, 3);
      end else if (exp_req) begin
        check("addr_stable", icache_addr_out, req_addr);
      end
      req_prev = exp_req;
    end

    check("mid_reset_done", 32'(did_reset), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
